// File: rtl/dpll_pkg.sv
// Shared DPLL types and constants: loop-bandwidth state and kMode defaults.
package dpll_pkg;

  localparam int unsigned KModeWidth = 4;

  localparam logic [KModeWidth-1:0] KMinDefault = 4'd3;
  localparam logic [KModeWidth-1:0] KMaxDefault = 4'd7;

  typedef enum logic [1:0] {
    StAcquire,
    StTrack,
    StLocked
  } dpllState_e;

endpackage

// File: rtl/sync2.sv
// Generic 2-flop bit synchronizer for asynchronous DPLL inputs.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/dpll_bw_controller.sv
// Loop-bandwidth scheduler and lock detector: measures phase-error duty per window and
// steps kMode from acquisition to tracking as consecutive good windows accumulate.
module dpll_bw_controller
  import dpll_pkg::*;
#(
  parameter int unsigned WINDOW_LOG2   = 8,
  parameter int unsigned LOCK_THRESH   = 16,
  parameter int unsigned UNLOCK_THRESH = 64,
  parameter int unsigned LOCK_WINDOWS  = 4,
  parameter logic [KModeWidth-1:0] K_MIN = KMinDefault,
  parameter logic [KModeWidth-1:0] K_MAX = KMaxDefault
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  errIn,
  output logic [KModeWidth-1:0] kMode,
  output logic                  kStrobe,
  output logic                  locked,
  output logic                  windowDone,
  output logic [WINDOW_LOG2:0]  errCount
);

  localparam int unsigned CntW  = WINDOW_LOG2 + 1;
  localparam int unsigned GcntW = (LOCK_WINDOWS > 1) ? $clog2(LOCK_WINDOWS) : 1;
  localparam logic [CntW-1:0]  LockThr   = CntW'(LOCK_THRESH);
  localparam logic [CntW-1:0]  UnlockThr = CntW'(UNLOCK_THRESH);
  localparam logic [GcntW-1:0] GcntFull  = GcntW'(LOCK_WINDOWS - 1);

  logic                   errS;
  logic [WINDOW_LOG2-1:0] wcnt_q;
  logic [CntW-1:0]        acc_q;
  logic [CntW-1:0]        errCount_q;
  logic [CntW-1:0]        evalCount;
  logic [GcntW-1:0]       gcnt_q;
  logic [KModeWidth-1:0]  kMode_q;
  logic [KModeWidth-1:0]  kNext;
  dpllState_e             state_q;
  logic                   locked_q;
  logic                   kStrobe_q;
  logic                   windowDone_q;
  logic                   terminal;
  logic                   good;
  logic                   bad;

  sync2 u_errSync (
    .clk  (clk),
    .reset(reset),
    .d    (errIn),
    .q    (errS)
  );

  // The terminal cycle's own error sample is folded into the evaluated count.
  assign evalCount = acc_q + CntW'(errS);
  assign terminal  = enable && (&wcnt_q);
  assign good      = evalCount < LockThr;
  assign bad       = evalCount >= UnlockThr;
  assign kNext     = kMode_q + KModeWidth'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q       <= '0;
      acc_q        <= '0;
      errCount_q   <= '0;
      gcnt_q       <= '0;
      kMode_q      <= K_MIN;
      state_q      <= StAcquire;
      locked_q     <= 1'b0;
      kStrobe_q    <= 1'b0;
      windowDone_q <= 1'b0;
    end else begin
      kStrobe_q    <= 1'b0;
      windowDone_q <= 1'b0;
      if (!enable) begin
        wcnt_q <= '0;
        acc_q  <= '0;
      end else if (!terminal) begin
        wcnt_q <= wcnt_q + WINDOW_LOG2'(1);
        acc_q  <= acc_q + CntW'(errS);
      end else begin
        wcnt_q       <= '0;
        acc_q        <= '0;
        errCount_q   <= evalCount;
        windowDone_q <= 1'b1;
        if (bad) begin
          gcnt_q <= '0;
          if (state_q != StAcquire) begin
            state_q   <= StAcquire;
            kMode_q   <= K_MIN;
            locked_q  <= 1'b0;
            kStrobe_q <= (kMode_q != K_MIN);
          end
        end else if (state_q == StLocked) begin
          gcnt_q <= '0;
        end else if (!good) begin
          gcnt_q <= '0;
        end else if (gcnt_q != GcntFull) begin
          gcnt_q <= gcnt_q + GcntW'(1);
        end else begin
          gcnt_q <= '0;
          // K_MIN == K_MAX lands here straight from acquisition: lock without a step.
          if (kMode_q == K_MAX) begin
            state_q  <= StLocked;
            locked_q <= 1'b1;
          end else begin
            kMode_q   <= kNext;
            kStrobe_q <= 1'b1;
            if (kNext == K_MAX) begin
              state_q  <= StLocked;
              locked_q <= 1'b1;
            end else begin
              state_q <= StTrack;
            end
          end
        end
      end
    end
  end

  assign kMode      = kMode_q;
  assign kStrobe    = kStrobe_q;
  assign locked     = locked_q;
  assign windowDone = windowDone_q;
  assign errCount   = errCount_q;

endmodule

// File: tb/tb_dpll_bw_controller.sv
// Directed bench for dpll_bw_controller with default parameters.
module tb_dpll_bw_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       errIn;
  logic [3:0] kMode;
  logic       kStrobe;
  logic       locked;
  logic       windowDone;
  logic [8:0] errCount;

  int nChecks = 0;
  int nFails = 0;
  // Stimulus modes: 0 = constant, 1 = period-4 square wave, 2 = high for first nErr cycles.
  int mode = 0;
  int phase = 0;
  int nErr = 0;
  logic constVal = 1'b0;
  int strobeCnt = 0;
  int wdCnt = 0;
  int cycCnt = 0;

  always #5 clk = ~clk;

  dpll_bw_controller dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .errIn     (errIn),
    .kMode     (kMode),
    .kStrobe   (kStrobe),
    .locked    (locked),
    .windowDone(windowDone),
    .errCount  (errCount)
  );

  task automatic checkVal(input string tag, input int got, input int exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    case (mode)
      0:       errIn = constVal;
      1:       errIn = ((phase % 4) < 2);
      default: errIn = (phase < nErr);
    endcase
    phase++;
    @(posedge clk);
    #1;
    cycCnt++;
    if (kStrobe) strobeCnt++;
    if (windowDone) wdCnt++;
  endtask

  task automatic waitWindow(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!windowDone && n < 400);
    checkVal({tag, " period"}, n, 256);
    phase = 0;
  endtask

  task automatic sendWindow(input int n, input string tag, input int expK, input int expStrobe);
    mode = 2;
    nErr = n;
    waitWindow(tag);
    checkVal({tag, " errCount"}, int'(errCount), n);
    checkVal({tag, " kMode"}, int'(kMode), expK);
    checkVal({tag, " kStrobe"}, int'(kStrobe), expStrobe);
    checkVal({tag, " locked"}, int'(locked), 0);
  endtask

  initial begin
    int c0;
    int s0;
    int w0;
    reset  = 1'b1;
    enable = 1'b1;
    errIn  = 1'b0;
    repeat (3) tick();
    checkVal("rst kMode", int'(kMode), 3);
    checkVal("rst locked", int'(locked), 0);
    checkVal("rst kStrobe", int'(kStrobe), 0);
    checkVal("rst windowDone", int'(windowDone), 0);
    checkVal("rst errCount", int'(errCount), 0);

    // Acquisition with a clean error signal.
    reset = 1'b0;
    c0 = cycCnt;
    s0 = strobeCnt;
    for (int w = 1; w <= 16; w++) begin
      waitWindow("acq");
      checkVal("acq errCount", int'(errCount), 0);
      checkVal("acq kMode", int'(kMode), 3 + w / 4);
      checkVal("acq kStrobe", int'(kStrobe), (w % 4 == 0) ? 1 : 0);
      checkVal("acq locked", int'(locked), (w == 16) ? 1 : 0);
    end
    checkVal("acq cycles", cycCnt - c0, 4096);
    checkVal("acq strobes", strobeCnt - s0, 4);

    // Loss of lock: 50% square wave.
    mode = 1;
    s0 = strobeCnt;
    waitWindow("unlock");
    checkVal("unlock errCount", int'(errCount), 128);
    checkVal("unlock kMode", int'(kMode), 3);
    checkVal("unlock locked", int'(locked), 0);
    checkVal("unlock kStrobe", int'(kStrobe), 1);
    checkVal("unlock strobes", strobeCnt - s0, 1);

    // Mid window after three good ones restarts the good-window run.
    repeat (3) sendWindow(15, "good15", 3, 0);
    sendWindow(32, "mid32", 3, 0);
    repeat (3) sendWindow(0, "postmid", 3, 0);
    sendWindow(0, "step4", 4, 1);

    // Boundary: 16 is mid, 63 is mid, 64 is bad.
    repeat (3) sendWindow(15, "trk15", 4, 0);
    sendWindow(16, "mid16", 4, 0);
    repeat (3) sendWindow(15, "post16", 4, 0);
    sendWindow(15, "step5", 5, 1);
    sendWindow(63, "mid63", 5, 0);
    sendWindow(64, "bad64", 3, 1);

    // No acquisition with errIn stuck high; the first window misses two synchronizer cycles.
    mode = 0;
    constVal = 1'b1;
    s0 = strobeCnt;
    waitWindow("noacq0");
    checkVal("noacq0 errCount", int'(errCount), 254);
    for (int w = 0; w < 3; w++) begin
      waitWindow("noacq");
      checkVal("noacq errCount", int'(errCount), 256);
      checkVal("noacq kMode", int'(kMode), 3);
      checkVal("noacq locked", int'(locked), 0);
    end
    checkVal("noacq strobes", strobeCnt - s0, 0);

    // Reset mid-window with 50 errors accumulated.
    mode = 2;
    nErr = 50;
    repeat (100) tick();
    reset = 1'b1;
    mode = 0;
    constVal = 1'b0;
    repeat (2) tick();
    checkVal("mrst kMode", int'(kMode), 3);
    checkVal("mrst locked", int'(locked), 0);
    checkVal("mrst kStrobe", int'(kStrobe), 0);
    checkVal("mrst windowDone", int'(windowDone), 0);
    checkVal("mrst errCount", int'(errCount), 0);
    reset = 1'b0;
    waitWindow("postrst");
    checkVal("postrst errCount", int'(errCount), 0);
    checkVal("postrst kMode", int'(kMode), 3);

    // Enable low for 1000 cycles holds state and gcnt.
    repeat (2) sendWindow(5, "predis", 3, 0);
    mode = 2;
    nErr = 5;
    repeat (10) tick();
    enable = 1'b0;
    w0 = wdCnt;
    s0 = strobeCnt;
    repeat (1000) tick();
    checkVal("dis windowDone", wdCnt - w0, 0);
    checkVal("dis strobes", strobeCnt - s0, 0);
    checkVal("dis kMode", int'(kMode), 3);
    checkVal("dis errCount", int'(errCount), 5);
    checkVal("dis locked", int'(locked), 0);
    enable = 1'b1;
    phase = 0;
    waitWindow("reen");
    checkVal("reen errCount", int'(errCount), 5);
    checkVal("reen kMode", int'(kMode), 4);
    checkVal("reen kStrobe", int'(kStrobe), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
